// File: rtl/sipo_deserializer_pkg.sv
// Shared SIPO/PISO definitions: default word width, FSM encoding
// and the bit-counter width derivation.
package sipo_deserializer_pkg;

    localparam int D_SIZE_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int d);
        return (d < 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/sipo_deserializer_out_buf.sv
// Output holding register for the SIPO stage: valid/ready handshake
// plus the sticky overrun flag for words dropped under backpressure.
module sipo_out_buf
    import sipo_deserializer_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [D_SIZE-1:0] word,
    input  logic              out_ready,
    input  logic              clr_overrun,
    output logic [D_SIZE-1:0] parallel_out,
    output logic              out_valid,
    output logic              overrun
);

    logic xfer;
    logic take;
    logic drop;

    assign xfer = out_valid & out_ready;
    // A consumed slot can be refilled on the same edge.
    assign take = load & (~out_valid | out_ready);
    assign drop = load & out_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
        end else if (take) begin
            parallel_out <= word;
            out_valid    <= 1'b1;
        end else if (xfer) begin
            out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receive stage, LSB first, with a
// double-buffered parallel output.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bit_valid,
    input  logic              serial_in,
    input  logic              out_ready,
    input  logic              clr_overrun,
    output logic [D_SIZE-1:0] parallel_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W = cnt_width(D_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_SIZE - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [D_SIZE-1:0] sr;
    logic [D_SIZE-1:0] sr_next;
    logic              last_bit;
    logic              sr_unused;

    assign sr_next   = {serial_in, sr[D_SIZE-1:1]};
    assign sr_unused = sr[0];
    assign busy      = (state == SHIFT);
    assign last_bit  = (state == SHIFT) & bit_valid & ~start
                     & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else if (bit_valid) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= sr_next;
                        cnt   <= CNT_W'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr <= sr_next;
                    if (start) begin
                        // Restart discards the partial frame silently.
                        cnt <= CNT_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sipo_out_buf #(
        .D_SIZE(D_SIZE)
    ) u_out_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (last_bit),
        .word         (sr_next),
        .out_ready    (out_ready),
        .clr_overrun  (clr_overrun),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

endmodule
